// File: rtl/core_pkg.sv
// Shared core definitions: AXI read response codes, instruction SRAM FSM states, reset PC.
package core_pkg;

    localparam logic [31:0] RESET_PC    = 32'h8000_0000;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } isram_state_e;

endpackage

// File: rtl/isram_array.sv
// DEPTH x 32 instruction storage: one write port, one read port sampled into a register.
module isram_array #(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    // Storage is not reset so program images survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-edge write is not visible here: the sample sees the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clr ? 32'h0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/ifu_isram.sv
// AXI4-lite read-only instruction SRAM for the IFU with a fixed, parameterised access latency.
module ifu_isram
    import core_pkg::*;
#(
    parameter logic [31:0] BASE    = RESET_PC,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ifu_arvalid,
    input  logic [31:0]              ifu_araddr,
    output logic                     ifu_arready,
    output logic                     ifu_rvalid,
    input  logic                     ifu_rready,
    output logic [31:0]              ifu_rdata,
    output logic [1:0]               ifu_rresp,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = 4;
    localparam logic [32:0] ADDR_LO = {1'b0, BASE};
    localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(DEPTH) << 2);

    isram_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic           arready_q, arready_d;
    logic           rvalid_q, rvalid_d;
    logic [1:0]     rresp_q, rresp_d;
    logic           sample_c;
    logic [1:0]     resp_c;
    logic [AW-1:0]  word_idx_c;

    // Decode of the latched fetch address; misalignment wins over range.
    always_comb begin
        word_idx_c = AW'((addr_q - BASE) >> 2);
        if (addr_q[1:0] != 2'b00) begin
            resp_c = RESP_SLVERR;
        end else if (({1'b0, addr_q} < ADDR_LO) || ({1'b0, addr_q} >= ADDR_HI)) begin
            resp_c = RESP_DECERR;
        end else begin
            resp_c = RESP_OKAY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        sample_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ifu_arvalid && arready_q) begin
                    addr_d    = ifu_araddr;
                    arready_d = 1'b0;
                    cnt_d     = CW'(LATENCY - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    sample_c = 1'b1;
                    rvalid_d = 1'b1;
                    rresp_d  = resp_c;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (ifu_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    isram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (sample_c),
        .rd_clr  (resp_c != RESP_OKAY),
        .rd_addr (word_idx_c),
        .rd_data (ifu_rdata)
    );

    assign ifu_arready = arready_q;
    assign ifu_rvalid  = rvalid_q;
    assign ifu_rresp   = rresp_q;

endmodule

// File: tb/tb_ifu_isram.sv
// Self-checking bench for ifu_isram against a word-array reference of the fetch rules.
module tb_ifu_isram;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int unsigned DEPTH   = 4096;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned AW      = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_arvalid = 1'b0;
    logic [31:0]   ifu_araddr = '0;
    logic          ifu_arready;
    logic          ifu_rvalid;
    logic          ifu_rready = 1'b0;
    logic [31:0]   ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    ifu_isram #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk         (clk),
        .rst         (rst),
        .ifu_arvalid (ifu_arvalid),
        .ifu_araddr  (ifu_araddr),
        .ifu_arready (ifu_arready),
        .ifu_rvalid  (ifu_rvalid),
        .ifu_rready  (ifu_rready),
        .ifu_rdata   (ifu_rdata),
        .ifu_rresp   (ifu_rresp),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data)
    );

    // Reference: byte address -> (data, resp) from plain 64-bit arithmetic.
    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        longint unsigned la;
        la = 64'(a);
        d  = 32'h0;
        if (a[1:0] != 2'b00) r = 2'b10;
        else if (la < 64'(BASE) || la >= 64'(BASE) + 64'(4 * DEPTH)) r = 2'b11;
        else begin
            r = 2'b00;
            d = model_mem[int'((la - 64'(BASE)) / 4)];
        end
    endfunction

    task automatic load_word(input int idx, input logic [31:0] data);
        load_en = 1'b1; load_addr = AW'(idx); load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[idx] = data;
    endtask

    // One full read transaction; delay<0 keeps rready high from the AR phase on.
    task automatic fetch(input logic [31:0] addr, input int delay,
                         output bit acc, output bit ar_drop, output int lat,
                         output logic [31:0] d, output logic [1:0] r,
                         output bit stable, output bit released);
        int cyc;
        bit pre;
        acc = 0; ar_drop = 0; lat = 0; d = '0; r = '0; stable = 1; released = 0; cyc = 0;
        ifu_rready  = (delay < 0);
        ifu_arvalid = 1'b1;
        ifu_araddr  = addr;
        while (!acc && cyc < 20) begin
            pre = ifu_arready;
            @(posedge clk); #1;
            cyc++;
            if (pre) acc = 1;
        end
        ifu_arvalid = 1'b0;
        ifu_araddr  = $urandom;
        if (!acc) begin ifu_rready = 1'b0; return; end
        ar_drop = (ifu_arready === 1'b0);
        while (ifu_rvalid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        d = ifu_rdata; r = ifu_rresp;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            if (ifu_rvalid !== 1'b1 || ifu_rdata !== d || ifu_rresp !== r || ifu_arready !== 1'b0) stable = 0;
        end
        ifu_rready = 1'b1;
        @(posedge clk); #1;
        released = (ifu_rvalid === 1'b0 && ifu_arready === 1'b1);
        ifu_rready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b, want all zero",
                     ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp);
        end
        // Preload the whole image while held in reset.
        for (int i = 0; i < int'(DEPTH); i++) load_word(i, $urandom);
        load_word(0, 32'h0000_0413);
        load_word(1, 32'h0010_0513);
        n_tests++;
        if (ifu_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_arready: got %b want 0", ifu_arready);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (ifu_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_before_edge: arready got %b want 0", ifu_arready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ifu_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_first_edge: arready got %b want 1", ifu_arready);
        end
    endtask

    task automatic test_basic();
        bit acc, drop, st, rel; int lat; logic [31:0] d; logic [1:0] r;
        fetch(BASE, -1, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if ({acc, drop, rel} !== 3'b111 || lat != int'(LATENCY)) begin
            n_fail++;
            $display("FAIL basic_timing: acc=%b ar_drop=%b released=%b latency=%0d, want 1 1 1 %0d", acc, drop, rel, lat, LATENCY);
        end
        n_tests++;
        if (d !== 32'h0000_0413 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_word0: got %h/%b want 00000413/00", d, r);
        end
        fetch(BASE + 32'd4, -1, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (d !== 32'h0010_0513 || r !== 2'b00 || lat != int'(LATENCY)) begin
            n_fail++;
            $display("FAIL basic_word1: got %h/%b lat=%0d want 00100513/00 lat=%0d", d, r, lat, LATENCY);
        end
    endtask

    task automatic test_backpressure();
        bit acc, drop, st, rel; int lat; logic [31:0] d, ed; logic [1:0] r, er;
        model_read(BASE + 32'd8, ed, er);
        fetch(BASE + 32'd8, 5, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stable: stable=%b want 1", st);
        end
        n_tests++;
        if (rel !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: released=%b want 1", rel);
        end
        n_tests++;
        if (d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL bp_data: got %h/%b want %h/%b", d, r, ed, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        logic [1:0]  resps [5];
        bit acc, drop, st, rel; int lat; logic [31:0] d; logic [1:0] r;
        addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_4000, 32'hFFFF_FFFC, 32'h7FFF_FFFF};
        resps = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        for (int i = 0; i < 5; i++) begin
            fetch(addrs[i], 0, acc, drop, lat, d, r, st, rel);
            n_tests++;
            if (d !== 32'h0 || r !== resps[i] || !rel) begin
                n_fail++;
                $display("FAIL err_%h: got %h/%b rel=%b want 00000000/%b", addrs[i], d, r, rel, resps[i]);
            end
        end
        fetch(32'h8000_3FFC, 1, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (d !== model_mem[DEPTH-1] || r !== 2'b00) begin
            n_fail++;
            $display("FAIL last_word: got %h/%b want %h/00", d, r, model_mem[DEPTH-1]);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_word;
        bit acc, drop, st, rel; int lat; logic [31:0] d; logic [1:0] r;
        old_word = model_mem[0];
        ifu_arvalid = 1'b1; ifu_araddr = BASE;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin @(posedge clk); #1; end
        load_word(0, 32'hDEAD_BEEF);
        n_tests++;
        if (ifu_rvalid !== 1'b1 || ifu_rdata !== old_word || ifu_rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_old: rvalid=%b rdata=%h rresp=%b want 1 %h 00", ifu_rvalid, ifu_rdata, ifu_rresp, old_word);
        end
        ifu_rready = 1'b1;
        @(posedge clk); #1;
        ifu_rready = 1'b0;
        fetch(BASE, 0, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            n_fail++;
            $display("FAIL collision_new: got %h/%b want deadbeef/00", d, r);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        bit acc, drop, st, rel; int lat; logic [31:0] d; logic [1:0] r;
        logic [31:0] w7;
        ifu_arvalid = 1'b1; ifu_araddr = BASE + 32'd12;
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (ifu_arready !== 1'b0 || ifu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: arready=%b rvalid=%b want 0 0", ifu_arready, ifu_rvalid);
        end
        @(posedge clk); #1;
        w7 = $urandom;
        load_word(7, w7);
        @(posedge clk); #4;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (ifu_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_arready: got %b want 1", ifu_arready);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (ifu_rvalid !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL aborted_response: rvalid seen=%b want 0", seen);
        end
        fetch(BASE, 0, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (d !== model_mem[0] || r !== 2'b00 || lat != int'(LATENCY)) begin
            n_fail++;
            $display("FAIL mem_kept: got %h/%b lat=%0d want %h/00 lat=%0d", d, r, lat, model_mem[0], LATENCY);
        end
        fetch(BASE + 32'd28, 0, acc, drop, lat, d, r, st, rel);
        n_tests++;
        if (d !== w7 || r !== 2'b00) begin
            n_fail++;
            $display("FAIL load_in_reset: got %h/%b want %h/00", d, r, w7);
        end
    endtask

    task automatic test_idle_noise();
        bit bad;
        bad = 0;
        ifu_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ifu_rvalid !== 1'b0 || ifu_arready !== 1'b1) bad = 1;
        end
        ifu_rready = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_rready_noise: rvalid=%b arready=%b want 0 1", ifu_rvalid, ifu_arready);
        end
    endtask

    task automatic test_random();
        bit acc, drop, st, rel; int lat, delay; logic [31:0] a, d, ed; logic [1:0] r, er;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            case ($urandom_range(0, 9))
                0:       a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
                1:       a = BASE - (32'($urandom_range(1, 100)) << 2);
                2:       a = BASE + 32'(4 * DEPTH) + (32'($urandom_range(0, 100)) << 2);
                default: a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
            endcase
            delay = int'($urandom_range(0, 4)) - 1;
            model_read(a, ed, er);
            fetch(a, delay, acc, drop, lat, d, r, st, rel);
            n_tests++;
            if (!acc || !drop || !st || !rel || lat != int'(LATENCY) || d !== ed || r !== er) begin
                n_fail++;
                $display("FAIL random_%0d addr=%h: got %h/%b lat=%0d acc=%b drop=%b stable=%b rel=%b want %h/%b lat=%0d",
                         n, a, d, r, lat, acc, drop, st, rel, ed, er, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_collision();
        test_reset_mid_wait();
        test_idle_noise();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
